// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and memory-bus signal bundle for mem_access_unit
//
// Purpose: groups the core-side request/response handshake and the external
// memory bus of mem_access_unit into one parameterised interface.
// Parameters: ADDR_W (address width), DATA_W (bus width, 32 or 64).
// Modports:
//   slave  - the memory access unit itself (takes i* signals, drives o* signals)
//   master - the environment (core + memory bus) driving the unit
// Signals:
//   iReqValid/oReqReady, iReqWrite, iReqSize, iReqSigned, iReqAddr, iReqWData : request
//   oRspValid, oRspData, oRspErr                                              : response
//   oMemAddr, oMemData, oMemByteEn, oMemRead, oMemWrite, iMemData, iRdy        : memory bus
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int NL = DATA_W / 8;

    logic              iReqValid;
    logic              oReqReady;
    logic              iReqWrite;
    logic [1:0]        iReqSize;
    logic              iReqSigned;
    logic [ADDR_W-1:0] iReqAddr;
    logic [DATA_W-1:0] iReqWData;

    logic              oRspValid;
    logic [DATA_W-1:0] oRspData;
    logic [1:0]        oRspErr;

    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oMemData;
    logic [NL-1:0]     oMemByteEn;
    logic              oMemRead;
    logic              oMemWrite;
    logic [DATA_W-1:0] iMemData;
    logic              iRdy;

    modport slave (
        input  iReqValid, iReqWrite, iReqSize, iReqSigned, iReqAddr, iReqWData,
        input  iMemData, iRdy,
        output oReqReady, oRspValid, oRspData, oRspErr,
        output oMemAddr, oMemData, oMemByteEn, oMemRead, oMemWrite
    );

    modport master (
        output iReqValid, iReqWrite, iReqSize, iReqSigned, iReqAddr, iReqWData,
        output iMemData, iRdy,
        input  oReqReady, oRspValid, oRspData, oRspErr,
        input  oMemAddr, oMemData, oMemByteEn, oMemRead, oMemWrite
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-request load/store unit with alignment, byte enables, extension and bus timeout
//
// Purpose: accepts one load/store at a time from the core, checks alignment,
// drives an aligned memory-bus access with byte enables and lane-shifted
// store data, waits on iRdy (with optional timeout) and returns a one-cycle
// response carrying sign/zero-extended load data and an error code.
// Parameters: ADDR_W, DATA_W (32 or 64), TIMEOUT (0 disables the timeout).
// Ports:
//   iClk  - clock, rising edge
//   iRst  - synchronous active-high reset
//   bus   - mem_access_unit_if.slave: request, response and memory-bus signals
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             iClk,
    input  logic             iRst,
    mem_access_unit_if.slave bus
);
    localparam int NL      = DATA_W / 8;
    localparam int OFF_W   = $clog2(NL);
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // The counter only ever needs to reach TIMEOUT-1: the cycle holding that
    // value is the last strobe cycle.
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q;
    logic              write_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic [NL-1:0]     byte_en_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              rsp_valid_q;
    logic [1:0]        rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [CNT_W-1:0]  wait_q;

    logic [OFF_W-1:0]  req_off;
    logic              req_bad;
    logic [NL-1:0]     byte_en_d;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] mem_data_d;
    logic [DATA_W-1:0] ld_shift;
    logic              ld_msb;
    logic [DATA_W-1:0] ld_data_d;

    always_comb begin
        req_off   = bus.iReqAddr[OFF_W-1:0];
        req_bad   = 1'b0;
        byte_en_d = '0;
        case (bus.iReqSize)
            2'd0: begin
                byte_en_d = NL'(1) << req_off;
            end
            2'd1: begin
                req_bad   = bus.iReqAddr[0];
                byte_en_d = NL'(3) << req_off;
            end
            2'd2: begin
                req_bad   = |bus.iReqAddr[1:0];
                byte_en_d = NL'(15) << req_off;
            end
            default: begin
                req_bad   = (DATA_W == 32) || (|bus.iReqAddr[2:0]);
                byte_en_d = {NL{1'b1}};
            end
        endcase

        // Zero every lane the access does not touch, so junk above the
        // right-justified store data never reaches the bus.
        lane_mask = '0;
        for (int i = 0; i < NL; i++) begin
            lane_mask[8*i +: 8] = {8{byte_en_d[i]}};
        end
        mem_data_d = (bus.iReqWData << {req_off, 3'b000}) & lane_mask;

        ld_shift = bus.iMemData >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ld_msb = ld_shift[7];
            2'd1:    ld_msb = ld_shift[15];
            2'd2:    ld_msb = ld_shift[31];
            default: ld_msb = ld_shift[DATA_W-1];
        endcase
        ld_data_d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ld_data_d[i] = (i < (8 << size_q)) ? ld_shift[i] : (signed_q & ld_msb);
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= 2'd0;
            off_q       <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            byte_en_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 2'b00;
            rsp_data_q  <= '0;
            wait_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.iReqValid) begin
                        write_q  <= bus.iReqWrite;
                        signed_q <= bus.iReqSigned;
                        size_q   <= bus.iReqSize;
                        off_q    <= req_off;
                        wait_q   <= '0;
                        if (req_bad) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 2'b01;
                            rsp_data_q  <= '0;
                        end else begin
                            state_q     <= ACCESS;
                            mem_addr_q  <= {bus.iReqAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_data_q  <= mem_data_d;
                            byte_en_q   <= byte_en_d;
                            mem_read_q  <= ~bus.iReqWrite;
                            mem_write_q <= bus.iReqWrite;
                        end
                    end
                end
                ACCESS: begin
                    // iRdy is tested first so it wins a tie with the timeout.
                    if (bus.iRdy || ((TIMEOUT != 0) && (wait_q == CNT_W'(TO_LAST)))) begin
                        state_q     <= RESP;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_data_q  <= '0;
                        byte_en_q   <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.iRdy ? 2'b00 : 2'b10;
                        rsp_data_q  <= (bus.iRdy && !write_q) ? ld_data_d : '0;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 2'b00;
                    rsp_data_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.oReqReady  = (state_q == IDLE);
    assign bus.oRspValid  = rsp_valid_q;
    assign bus.oRspData   = rsp_data_q;
    assign bus.oRspErr    = rsp_err_q;
    assign bus.oMemAddr   = mem_addr_q;
    assign bus.oMemData   = mem_data_q;
    assign bus.oMemByteEn = byte_en_q;
    assign bus.oMemRead   = mem_read_q;
    assign bus.oMemWrite  = mem_write_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit (32-bit and 64-bit instances)
module tb_mem_access_unit;
    logic iClk = 1'b0;
    logic iRst = 1'b1;
    always #5 iClk = ~iClk;

    int errors = 0;
    int checks = 0;
    int n;
    bit stable;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) b32 ();
    mem_access_unit_if #(.ADDR_W(32), .DATA_W(64)) b64 ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut32 (
        .iClk(iClk), .iRst(iRst), .bus(b32)
    );
    mem_access_unit #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(255)) dut64 (
        .iClk(iClk), .iRst(iRst), .bus(b64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic req32(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        b32.iReqValid = 1'b1; b32.iReqWrite = w; b32.iReqSize = sz;
        b32.iReqSigned = sg; b32.iReqAddr = a; b32.iReqWData = wd;
        @(negedge iClk);
        b32.iReqValid = 1'b0;
    endtask

    task automatic req64(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [63:0] wd);
        b64.iReqValid = 1'b1; b64.iReqWrite = w; b64.iReqSize = sz;
        b64.iReqSigned = sg; b64.iReqAddr = a; b64.iReqWData = wd;
        @(negedge iClk);
        b64.iReqValid = 1'b0;
    endtask

    // Counts strobe cycles on the 32-bit unit until the response, raising iRdy
    // in strobe cycle rdy_at (never when negative); bounded to 20 cycles.
    task automatic run32(input int rdy_at, output int cnt, output bit stab);
        logic [31:0] a0, d0;
        cnt = 0; stab = 1'b1;
        a0 = b32.oMemAddr; d0 = b32.oMemData;
        for (int i = 0; i < 20; i++) begin
            if (b32.oRspValid) break;
            if (b32.oMemRead || b32.oMemWrite) begin
                cnt++;
                if (b32.oMemAddr !== a0 || b32.oMemData !== d0) stab = 1'b0;
            end
            b32.iRdy = (i == rdy_at);
            @(negedge iClk);
        end
        b32.iRdy = 1'b0;
    endtask

    initial begin
        b32.iReqValid = 0; b32.iReqWrite = 0; b32.iReqSize = 0; b32.iReqSigned = 0;
        b32.iReqAddr = 0; b32.iReqWData = 0; b32.iMemData = 0; b32.iRdy = 0;
        b64.iReqValid = 0; b64.iReqWrite = 0; b64.iReqSize = 0; b64.iReqSigned = 0;
        b64.iReqAddr = 0; b64.iReqWData = 0; b64.iMemData = 0; b64.iRdy = 0;
        iRst = 1'b1;
        repeat (2) @(negedge iClk);

        // Reset state
        chk("rst_ready", 64'(b32.oReqReady), 64'h1);
        chk("rst_rspvalid", 64'(b32.oRspValid), 64'h0);
        chk("rst_rsperr", 64'(b32.oRspErr), 64'h0);
        chk("rst_strobes", 64'({b32.oMemRead, b32.oMemWrite}), 64'h0);
        chk("rst_be_addr_data", 64'({b32.oMemByteEn, b32.oMemAddr, b32.oMemData} != 0), 64'h0);
        chk("rst_rspdata64", b64.oRspData, 64'h0);
        iRst = 1'b0;
        @(negedge iClk);

        // Signed byte load at 0x1003, iRdy in the first ACCESS cycle
        req32(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0);
        chk("sb_read", 64'(b32.oMemRead), 64'h1);
        chk("sb_ready_low", 64'(b32.oReqReady), 64'h0);
        chk("sb_addr", 64'(b32.oMemAddr), 64'h1000);
        chk("sb_be", 64'(b32.oMemByteEn), 64'h8);
        b32.iRdy = 1'b1; b32.iMemData = 32'h80FF1234;
        @(negedge iClk);
        b32.iRdy = 1'b0;
        chk("sb_rspvalid", 64'(b32.oRspValid), 64'h1);
        chk("sb_rspdata", 64'(b32.oRspData), 64'hFFFFFF80);
        chk("sb_rsperr", 64'(b32.oRspErr), 64'h0);
        chk("sb_read_drop", 64'(b32.oMemRead), 64'h0);
        @(negedge iClk);
        chk("sb_valid_pulse", 64'(b32.oRspValid), 64'h0);
        chk("sb_ready_back", 64'(b32.oReqReady), 64'h1);

        // Half store at 0x2002 with three wait states
        req32(1'b1, 2'd1, 1'b0, 32'h2002, 32'h5555ABCD);
        chk("hs_addr", 64'(b32.oMemAddr), 64'h2000);
        chk("hs_data", 64'(b32.oMemData), 64'hABCD0000);
        chk("hs_be", 64'(b32.oMemByteEn), 64'hC);
        run32(3, n, stable);
        chk("hs_write_cycles", 64'(n), 64'd4);
        chk("hs_stable", 64'(stable), 64'h1);
        chk("hs_rspvalid", 64'(b32.oRspValid), 64'h1);
        chk("hs_rspdata", 64'(b32.oRspData), 64'h0);
        chk("hs_rsperr", 64'(b32.oRspErr), 64'h0);
        @(negedge iClk);

        // Misaligned word load and illegal dword on a 32-bit bus
        req32(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0);
        chk("mis_rspvalid", 64'(b32.oRspValid), 64'h1);
        chk("mis_rsperr", 64'(b32.oRspErr), 64'h1);
        chk("mis_noread", 64'(b32.oMemRead), 64'h0);
        @(negedge iClk);
        chk("mis_ready", 64'(b32.oReqReady), 64'h1);
        req32(1'b0, 2'd3, 1'b0, 32'h1000, 32'h0);
        chk("ill_rspvalid", 64'(b32.oRspValid), 64'h1);
        chk("ill_rsperr", 64'(b32.oRspErr), 64'h1);
        chk("ill_noread", 64'(b32.oMemRead), 64'h0);
        @(negedge iClk);

        // Timeout with iRdy held low, then a tie on the 4th cycle
        req32(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0);
        run32(-1, n, stable);
        chk("to_read_cycles", 64'(n), 64'd4);
        chk("to_rspvalid", 64'(b32.oRspValid), 64'h1);
        chk("to_rsperr", 64'(b32.oRspErr), 64'h2);
        chk("to_rspdata", 64'(b32.oRspData), 64'h0);
        @(negedge iClk);
        b32.iMemData = 32'h12345678;
        req32(1'b0, 2'd2, 1'b0, 32'h3004, 32'h0);
        run32(3, n, stable);
        chk("tie_read_cycles", 64'(n), 64'd4);
        chk("tie_rsperr", 64'(b32.oRspErr), 64'h0);
        chk("tie_rspdata", 64'(b32.oRspData), 64'h12345678);
        @(negedge iClk);

        // 64-bit dword load, then unsigned and signed byte loads from lane 7
        req64(1'b0, 2'd3, 1'b0, 32'h8, 64'h0);
        chk("dw_addr", 64'(b64.oMemAddr), 64'h8);
        chk("dw_be", 64'(b64.oMemByteEn), 64'hFF);
        b64.iRdy = 1'b1; b64.iMemData = 64'h0123456789ABCDEF;
        @(negedge iClk);
        b64.iRdy = 1'b0;
        chk("dw_rspdata", b64.oRspData, 64'h0123456789ABCDEF);
        @(negedge iClk);
        req64(1'b0, 2'd0, 1'b0, 32'hF, 64'h0);
        chk("ub_addr", 64'(b64.oMemAddr), 64'h8);
        chk("ub_be", 64'(b64.oMemByteEn), 64'h80);
        b64.iRdy = 1'b1; b64.iMemData = 64'h8100000000000000;
        @(negedge iClk);
        b64.iRdy = 1'b0;
        chk("ub_rspdata", b64.oRspData, 64'h81);
        chk("ub_rsperr", 64'(b64.oRspErr), 64'h0);
        @(negedge iClk);
        req64(1'b0, 2'd0, 1'b1, 32'hF, 64'h0);
        b64.iRdy = 1'b1;
        @(negedge iClk);
        b64.iRdy = 1'b0;
        chk("sb64_rspdata", b64.oRspData, 64'hFFFFFFFFFFFFFF81);
        @(negedge iClk);
        req64(1'b0, 2'd3, 1'b0, 32'hC, 64'h0);
        chk("mis64_rsperr", 64'(b64.oRspErr), 64'h1);
        @(negedge iClk);

        // Reset in the middle of an access
        req32(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0);
        chk("ra_read", 64'(b32.oMemRead), 64'h1);
        iRst = 1'b1;
        @(negedge iClk);
        chk("ra_strobe_drop", 64'(b32.oMemRead), 64'h0);
        chk("ra_novalid", 64'(b32.oRspValid), 64'h0);
        chk("ra_ready", 64'(b32.oReqReady), 64'h1);
        iRst = 1'b0;
        b32.iRdy = 1'b1;
        @(negedge iClk);
        b32.iRdy = 1'b0;
        chk("ra_novalid2", 64'(b32.oRspValid), 64'h0);
        b32.iMemData = 32'h80010000;
        req32(1'b0, 2'd1, 1'b1, 32'h4002, 32'h0);
        chk("ra_be", 64'(b32.oMemByteEn), 64'hC);
        run32(0, n, stable);
        chk("ra_cycles", 64'(n), 64'd1);
        chk("ra_rspvalid", 64'(b32.oRspValid), 64'h1);
        chk("ra_rspdata", 64'(b32.oRspData), 64'hFFFF8001);
        chk("ra_rsperr", 64'(b32.oRspErr), 64'h0);
        @(negedge iClk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory access unit sitting between the multi-cycle core's control/datapath and the external memory bus. It accepts one load or store request at a time and performs sub-word alignment, byte-enable generation and sign/zero extension. It adds wait-state handling on `iRdy` with a bus timeout and returns a single-cycle response with error status. It supersedes the core's fixed 32-bit, word-only memory registers.

## Interface
- `ADDR_W`, 32, address width in bits.
- `DATA_W`, 32, bus data width; legal values are 32 or 64. The lane count is `NL = DATA_W/8`.
- `TIMEOUT`, 255, number of `ACCESS` cycles without `iRdy` before an access aborts. A value of 0 disables the timeout.

Ports:
- `iClk`  in  1  clock; all logic is on the rising edge.
- `iRst`  in  1  reset; synchronous and active-high.
- `iReqValid`  in  1  request strobe from the core.
- `oReqReady`  out  1  unit is idle and can accept a request.
- `iReqWrite`  in  1  1 = store, 0 = load.
- `iReqSize`  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (dword is legal only when `DATA_W`=64).
- `iReqSigned`  in  1  sign-extend load data.
- `iReqAddr`  in  `ADDR_W`  byte address.
- `iReqWData`  in  `DATA_W`  store data, right-justified.
- `oRspValid`  out  1  one-cycle response pulse.
- `oRspData`  out  `DATA_W`  extended load data; 0 for stores and errors.
- `oRspErr`  out  2  00 = ok, 01 = misaligned/illegal size, 10 = timeout.
- `oMemAddr`  out  `ADDR_W`  bus address, aligned down to `NL` bytes.
- `oMemData`  out  `DATA_W`  store data, shifted into its lanes.
- `oMemByteEn`  out  `NL`  active lanes.
- `oMemRead`, `oMemWrite`  out  1  bus strobes.
- `iMemData`  in  `DATA_W`  bus read data.
- `iRdy`  in  1  bus completes the access this cycle.

## Operation
- The FSM has three states: `IDLE`, `ACCESS`, `RESP`. `oReqReady` = (state == `IDLE`).
- In `IDLE`, a request with `iReqValid`=1 is captured into internal registers.
  - Misalignment is tested as `addr mod 2^size != 0`.
  - An illegal size is size 3 with `DATA_W`=32.
  - If the request is misaligned or illegal, the next state is `RESP` with `oRspErr`=01 and no bus strobe is raised.
  - Otherwise the next state is `ACCESS`.
- In `ACCESS`:
  - `oMemRead` or `oMemWrite` is 1.
  - `oMemAddr`, `oMemData` and `oMemByteEn` are registered and held stable until completion.
  - Lane offset `off = addr[log2(NL)-1:0]`.
  - `oMemByteEn` = ((1 << 2^size) − 1) << `off`.
  - `oMemData` = `iReqWData` << (8·`off`); unused lanes are 0.
- Completion: `iRdy`=1 sampled in `ACCESS` ends the access.
  - For loads, `iMemData` >> (8·`off`) is masked to the access size, then sign-extended if `iReqSigned`=1, else zero-extended, and registered into `oRspData`.
  - Strobes drop and the next state is `RESP` with `oRspErr`=00.
- Timeout applies when `TIMEOUT`≠0.
  - A wait counter resets to 0 on entry to `ACCESS` and increments each `ACCESS` cycle while `iRdy`=0.
  - When the counter reaches `TIMEOUT`, strobes drop, the next state is `RESP`, `oRspErr`=10 and `oRspData`=0.
  - If `iRdy`=1 arrives in the same cycle the count is reached, `iRdy` wins and the response is ok.
- In `RESP`, `oRspValid`=1 for exactly one cycle (no backpressure), then the FSM returns to `IDLE`.
- `iReqValid` outside `IDLE` is ignored. The core must hold a request until it sees `oReqReady`=1.

## Timing
- Reset values:
  - state = `IDLE`, `oReqReady`=1.
  - `oRspValid`, `oRspErr`, `oRspData`, `oMemRead`, `oMemWrite`, `oMemByteEn`, `oMemAddr`, `oMemData` = 0.
  - Wait counter = 0.
- A request accepted at edge T gives `ACCESS` in cycle T+1. If `iRdy` is first high in cycle T+1+k, `oRspValid` is high in cycle T+2+k. Minimum load/store latency is 2 cycles (k=0).
- A misaligned request accepted at T gives `oRspValid` in cycle T+1.
- A timeout gives exactly `TIMEOUT` cycles of strobe, then `oRspValid` the following cycle.
- `oReqReady` returns high in the cycle after `oRspValid`. The maximum accepted-request rate is one per 3 cycles.
- Reset asserted mid-`ACCESS` drops the strobes at the next edge. No response is produced for the aborted request.
- `iRdy` is ignored outside `ACCESS`.
- All outputs come from registers or from state only; there are no combinational paths from inputs to outputs.

## Test plan
- **Signed byte load.** `DATA_W`=32, signed byte load at 0x1003, `iRdy` high in the first `ACCESS` cycle with `iMemData`=0x80FF1234.
  - Required: `oMemAddr`=0x1000, `oMemByteEn`=1000b, `oRspData`=0xFFFFFF80, `oRspErr`=00, response 2 cycles after acceptance.
- **Half store with wait states.** Half store at 0x2002 with data 0x0000ABCD, `iRdy` delayed 3 cycles.
  - Required: `oMemData`=0xABCD0000, `oMemByteEn`=1100b, `oMemWrite` held 4 cycles with stable address/data, `oRspData`=0.
- **Misaligned and illegal requests.** Word load at 0x1002, and size 3 with `DATA_W`=32.
  - Required: `oRspErr`=01 one cycle after acceptance, `oMemRead` never asserted.
- **Timeout and tie.** `TIMEOUT`=4 and `iRdy` held 0.
  - Required: `oMemRead` high exactly 4 cycles, then `oRspValid` with `oRspErr`=10.
  - Repeat with `iRdy` rising on the 4th cycle; required: `oRspErr`=00.
- **64-bit dword and zero extension.** `DATA_W`=64, unsigned dword load at 0x8, then unsigned byte load at 0xF with `iMemData`=0x8100…00.
  - Required: `oMemByteEn`=0xFF, then 0x80 with `oRspData`=0x81.
- **Reset mid-access.** `iRst` pulsed during `ACCESS`.
  - Required: strobes 0 at the next edge, no `oRspValid`, `oReqReady`=1, and a subsequent request completes normally.
